// File: rtl/sdram_burst_sched.sv
// Burst scheduler: manages an SDRAM region as a circular buffer and issues write/read burst requests.
// Latency: req rises one cycle after the IDLE decision; pointers/level update the cycle after done.
// Backpressure: req held until ack; no new burst until done, then at least one IDLE cycle.
module sdram_burst_sched #(
  parameter int ADDR_W       = 24,
  parameter int CNT_W        = 10,
  parameter int BURST_LEN    = 256,
  parameter int REGION_WORDS = 1048576,
  parameter int BASE_ADDR    = 0,
  parameter int W_THRESH     = 256,
  parameter int R_THRESH     = 256,
  parameter int PRIO_MODE    = 0,
  localparam int PTR_W       = $clog2(REGION_WORDS),
  localparam int LVL_W       = PTR_W + 1
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  w_data_count,
  input  logic [CNT_W-1:0]  r_data_count,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  input  logic              wr_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_done,
  input  logic              flush,
  output logic [LVL_W-1:0]  level,
  output logic              sd_full,
  output logic              sd_empty
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

  localparam logic [PTR_W-1:0]  STEP     = PTR_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  LVL_STEP = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  FULL_TH  = LVL_W'(REGION_WORDS - BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       W_TH     = 32'(W_THRESH);
  localparam logic [31:0]       R_TH     = 32'(R_THRESH);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W-1:0] wptr_inc, rptr_inc;
  logic             last_wr;     // 1 = last served burst was a write
  logic             flush_pend;
  logic             we, re;
  logic             wr_fin, rd_fin, flush_clr;

  assign sd_full  = (level > FULL_TH);
  assign sd_empty = (level < LVL_STEP);
  assign we       = (32'(w_data_count) >= W_TH) && !sd_full;
  assign re       = (32'(r_data_count) < R_TH) && !sd_empty;
  // Pointer arithmetic wraps naturally in PTR_W bits (region is a power of two).
  assign wptr_inc = wptr + STEP;
  assign rptr_inc = rptr + STEP;

  // State register
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision; a pending flush holds IDLE for the clearing cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!flush_pend) begin
          if (we && re)  state_nxt = ((PRIO_MODE != 0) || !last_wr) ? WR_REQ : RD_REQ;
          else if (we)   state_nxt = WR_REQ;
          else if (re)   state_nxt = RD_REQ;
        end
      end
      WR_REQ:  if (wr_ack)  state_nxt = WR_BUSY;
      WR_BUSY: if (wr_done) state_nxt = IDLE;
      RD_REQ:  if (rd_ack)  state_nxt = RD_BUSY;
      RD_BUSY: if (rd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from the registered state
  always_comb begin
    wr_req    = (state == WR_REQ);
    rd_req    = (state == RD_REQ);
    wr_fin    = (state == WR_BUSY) && wr_done;
    rd_fin    = (state == RD_BUSY) && rd_done;
    flush_clr = (state == IDLE) && flush_pend;
  end

  // Pointers, addresses, level, arbitration history and deferred flush
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      wr_addr    <= BASE;
      rd_addr    <= BASE;
      level      <= '0;
      last_wr    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (flush_clr) begin
        wptr    <= '0;
        rptr    <= '0;
        wr_addr <= BASE;
        rd_addr <= BASE;
        level   <= '0;
      end else if (wr_fin) begin
        wptr    <= wptr_inc;
        wr_addr <= BASE + ADDR_W'(wptr_inc);
        level   <= level + LVL_STEP;
        last_wr <= 1'b1;
      end else if (rd_fin) begin
        rptr    <= rptr_inc;
        rd_addr <= BASE + ADDR_W'(rptr_inc);
        level   <= level - LVL_STEP;
        last_wr <= 1'b0;
      end
      // A new flush pulse wins over the clear of an older one.
      flush_pend <= flush | (flush_pend & ~flush_clr);
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Bench for sdram_burst_sched: a round-robin and a write-priority instance over a 1024-word region,
// driven burst by burst with randomized counts, ack/done delays and stray pulses.
// Expected grants, addresses and levels come from a transaction-level model of the buffer.
module tb_sdram_burst_sched;
  localparam int AW = 24, CW = 10, BL = 256, RW = 1024, LW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic [CW-1:0] wcnt [2], rcnt [2];
  logic          wr_req [2], rd_req [2], wr_ack [2], rd_ack [2];
  logic          wr_done [2], rd_done [2], flush [2];
  logic          sd_full [2], sd_empty [2];
  logic [AW-1:0] wr_addr [2], rd_addr [2];
  logic [LW-1:0] level [2];

  int nvec = 0, nerr = 0;
  int m_lvl [2], m_wp [2], m_rp [2];
  bit m_lastw [2];

  sdram_burst_sched #(.ADDR_W(AW), .CNT_W(CW), .BURST_LEN(BL), .REGION_WORDS(RW), .BASE_ADDR('h1400),
                      .W_THRESH(256), .R_THRESH(256), .PRIO_MODE(0)) u_rr (
    .sysclk_100M(clk), .rst_n(rst_n[0]), .w_data_count(wcnt[0]), .r_data_count(rcnt[0]),
    .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_ack(wr_ack[0]), .wr_done(wr_done[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]), .rd_done(rd_done[0]),
    .flush(flush[0]), .level(level[0]), .sd_full(sd_full[0]), .sd_empty(sd_empty[0]));

  sdram_burst_sched #(.ADDR_W(AW), .CNT_W(CW), .BURST_LEN(BL), .REGION_WORDS(RW), .BASE_ADDR(0),
                      .W_THRESH(256), .R_THRESH(256), .PRIO_MODE(1)) u_pr (
    .sysclk_100M(clk), .rst_n(rst_n[1]), .w_data_count(wcnt[1]), .r_data_count(rcnt[1]),
    .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_ack(wr_ack[1]), .wr_done(wr_done[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]), .rd_done(rd_done[1]),
    .flush(flush[1]), .level(level[1]), .sd_full(sd_full[1]), .sd_empty(sd_empty[1]));

  function automatic int base(input int d);
    return (d == 0) ? 32'h1400 : 0;
  endfunction

  // 0 = no burst, 1 = write, 2 = read
  function automatic int exp_grant(input int d, input int w, input int r);
    bit we, re;
    we = (w >= 256) && (m_lvl[d] <= RW - BL);
    re = (r < 256) && (m_lvl[d] >= BL);
    if (we && re) return (d == 1 || !m_lastw[d]) ? 1 : 2;
    if (we) return 1;
    if (re) return 2;
    return 0;
  endfunction

  function automatic int pick(input bit is_w);
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 255;
      2:       return 256;
      3:       return 300;
      default: return is_w ? 1023 : 600;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input int d, input string tag);
    chk({tag, "_level"}, 32'(level[d]), 32'(m_lvl[d]));
    chk({tag, "_full"}, 32'(sd_full[d]), 32'(m_lvl[d] > RW - BL));
    chk({tag, "_empty"}, 32'(sd_empty[d]), 32'(m_lvl[d] < BL));
    chk({tag, "_wr_addr"}, 32'(wr_addr[d]), 32'(AW'(base(d) + m_wp[d])));
    chk({tag, "_rd_addr"}, 32'(rd_addr[d]), 32'(AW'(base(d) + m_rp[d])));
  endtask

  task automatic clr(input int d);
    wr_ack[d] = 1'b0; rd_ack[d] = 1'b0; wr_done[d] = 1'b0; rd_done[d] = 1'b0; flush[d] = 1'b0;
  endtask

  task automatic park(input int d);
    wcnt[d] = 10'd0; rcnt[d] = 10'd1023;
  endtask

  task automatic model_clear(input int d);
    m_lvl[d] = 0; m_wp[d] = 0; m_rp[d] = 0;
  endtask

  // One scheduling opportunity: present counts, check grant, handshake, check result.
  task automatic burst(input int d, input int w, input int r, input bit fl);
    int g, k;
    g = exp_grant(d, w, r);
    wcnt[d] = CW'(w); rcnt[d] = CW'(r);
    @(negedge clk);
    chk("wr_req_rise", 32'(wr_req[d]), 32'(g == 1));
    chk("rd_req_rise", 32'(rd_req[d]), 32'(g == 2));
    park(d);
    if (g == 0) begin
      repeat (2) @(negedge clk);
      chk("no_req", 32'({wr_req[d], rd_req[d]}), 32'd0);
      return;
    end
    k = $urandom_range(0, 3);
    repeat (k) begin
      if (g == 1) rd_ack[d] = 1'($urandom_range(0, 1));
      else        wr_ack[d] = 1'($urandom_range(0, 1));
      wr_done[d] = 1'($urandom_range(0, 1));
      rd_done[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      clr(d);
    end
    chk("req_hold", 32'(g == 1 ? wr_req[d] : rd_req[d]), 32'd1);
    chk("req_addr", 32'(g == 1 ? wr_addr[d] : rd_addr[d]),
        32'(AW'(base(d) + (g == 1 ? m_wp[d] : m_rp[d]))));
    chk("req_level", 32'(level[d]), 32'(m_lvl[d]));
    if (g == 1) wr_ack[d] = 1'b1; else rd_ack[d] = 1'b1;
    @(negedge clk);
    clr(d);
    chk("req_drop", 32'({wr_req[d], rd_req[d]}), 32'd0);
    if (fl) flush[d] = 1'b1;
    k = $urandom_range(0, 3);
    repeat (k) begin
      wr_ack[d] = 1'($urandom_range(0, 1));
      rd_ack[d] = 1'($urandom_range(0, 1));
      if (g == 1) rd_done[d] = 1'($urandom_range(0, 1));
      else        wr_done[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      clr(d);
    end
    chk("busy_level", 32'(level[d]), 32'(m_lvl[d]));
    chk("busy_noreq", 32'({wr_req[d], rd_req[d]}), 32'd0);
    if (g == 1) wr_done[d] = 1'b1; else rd_done[d] = 1'b1;
    @(negedge clk);
    clr(d);
    if (g == 1) begin
      m_lvl[d] += BL; m_wp[d] = (m_wp[d] + BL) % RW; m_lastw[d] = 1'b1;
    end else begin
      m_lvl[d] -= BL; m_rp[d] = (m_rp[d] + BL) % RW; m_lastw[d] = 1'b0;
    end
    chk_state(d, "done");
    if (fl) begin
      rcnt[d] = 10'd0;
      @(negedge clk);
      model_clear(d);
      chk_state(d, "dflush");
      @(negedge clk);
      chk("dflush_no_rd", 32'(rd_req[d]), 32'd0);
      park(d);
      @(negedge clk);
    end
  endtask

  task automatic flush_idle(input int d);
    flush[d] = 1'b1;
    @(negedge clk);
    clr(d);
    @(negedge clk);
    model_clear(d);
    chk_state(d, "iflush");
  endtask

  // Asynchronous reset while a read burst is in flight; its late done must be ignored.
  task automatic reset_mid(input int d);
    wcnt[d] = 10'd0; rcnt[d] = 10'd0;
    @(negedge clk);
    chk("rst_rd_req", 32'(rd_req[d]), 32'd1);
    park(d);
    rd_ack[d] = 1'b1;
    @(negedge clk);
    clr(d);
    @(negedge clk);
    #2 rst_n[d] = 1'b0;
    #1;
    model_clear(d);
    m_lastw[d] = 1'b0;
    chk("rst_async_rd_req", 32'(rd_req[d]), 32'd0);
    chk_state(d, "rst_async");
    @(negedge clk);
    rst_n[d] = 1'b1;
    rd_done[d] = 1'b1;
    @(negedge clk);
    clr(d);
    chk_state(d, "rst_late_done");
    chk("rst_late_rd_req", 32'(rd_req[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      clr(d);
      park(d);
      model_clear(d);
      m_lastw[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_reqs", 32'({wr_req[d], rd_req[d]}), 32'd0);
      chk_state(d, "reset");
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    // Round-robin instance: single writes, contention, fill to full, drain with wrap
    burst(0, 256, 300, 1'b0);
    burst(0, 256, 300, 1'b0);
    repeat (4) burst(0, 300, 0, 1'b0);
    repeat (3) burst(0, 300, 300, 1'b0);
    repeat (5) burst(0, 0, 0, 1'b0);
    burst(0, 300, 300, 1'b0);
    burst(0, 300, 300, 1'b0);
    flush_idle(0);
    burst(0, 300, 300, 1'b0);
    burst(0, 300, 300, 1'b1);
    burst(0, 255, 256, 1'b0);
    burst(0, 256, 255, 1'b0);
    reset_mid(0);
    for (int i = 0; i < 60; i++)
      burst(0, pick(1'b1), pick(1'b0), ($urandom_range(0, 7) == 0));

    // Write-priority instance: writes until full, then reads; then random
    repeat (6) burst(1, 300, 0, 1'b0);
    for (int i = 0; i < 60; i++)
      burst(1, pick(1'b1), pick(1'b0), ($urandom_range(0, 7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
